// File: rtl/fft_seq_pkg.sv
// Shared types and helpers for the FFT stream sequencer: FSM state encoding,
// default geometry and width helpers.
package fft_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    STREAM = 2'd2
  } state_e;

  localparam int unsigned DEF_DATA_W     = 14;
  localparam int unsigned DEF_NPTS       = 1024;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned FFT_PTS_W      = 11;

  function automatic int unsigned cnt_w_f(input int unsigned npts);
    return $clog2(npts);
  endfunction

  function automatic int unsigned ptr_w_f(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic logic [FFT_PTS_W-1:0] fft_pts_f(input int unsigned npts);
    return FFT_PTS_W'(npts);
  endfunction

endpackage

// File: rtl/fft_stream_sequencer_if.sv
// Avalon-ST link between the sequencer and the FFT core: sink beats toward the
// core plus the core's source-side status that the sequencer watches.
interface fft_stream_sequencer_if #(
  parameter int unsigned DATA_W = 14
);
  logic              sink_valid;
  logic              sink_ready;
  logic              sink_sop;
  logic              sink_eop;
  logic [DATA_W-1:0] sink_real;
  logic [DATA_W-1:0] sink_imag;
  logic [1:0]        sink_error;
  logic              source_valid;
  logic              source_eop;
  logic [1:0]        source_error;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    input  sink_ready, source_valid, source_eop, source_error
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_real, sink_imag, sink_error,
    output sink_ready, source_valid, source_eop, source_error
  );
endinterface

// File: rtl/fft_seq_fifo.sv
// Small synchronous FIFO with flush; a read on a full FIFO frees the slot for a
// same-cycle write.
module fft_seq_fifo
  import fft_seq_pkg::*;
#(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush_i,
  input  logic                      wr_en_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  input  logic                      rd_en_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic                      full_o,
  output logic                      empty_o,
  output logic [ptr_w_f(DEPTH):0]   level_o
);
  localparam int unsigned PTR_W = ptr_w_f(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    level_q, level_d;
  logic              push, pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PTR_W+1)'(DEPTH));
  assign pop     = rd_en_i & !empty_o;
  assign push    = wr_en_i & (!full_o | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule

// File: rtl/fft_stream_sequencer.sv
// Cuts a free-running sample stream into NPTS-point Avalon-ST frames for the FFT
// core and tracks frames in flight. Optional macro: FFT_SEQ_ERR_ABORT_EN.
module fft_stream_sequencer
  import fft_seq_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned NPTS       = DEF_NPTS,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        inverse_cfg,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  fft_stream_sequencer_if.master      sink,
  output logic                        inverse,
  output logic [FFT_PTS_W-1:0]        fft_pts,
  output logic [15:0]                 frames_sent,
  output logic                        overflow,
  output logic                        busy
);
  localparam int unsigned CNT_W = cnt_w_f(NPTS);
  localparam int unsigned LVL_W = ptr_w_f(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NPTS - 1);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inv_q, inv_d;
  logic [15:0]       frames_q, frames_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        outst_q, outst_d;

  logic              fifo_empty, fifo_full;
  logic [LVL_W-1:0]  fifo_level;
  logic [DATA_W-1:0] fifo_head;
  logic              valid_c, sop_c, eop_c, xfer, eop_xfer, src_eop;
  logic              more_next, start_ok, flush;

  fft_seq_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush_i   (flush),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (xfer),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign valid_c   = (state_q == STREAM) & !fifo_empty;
  assign sop_c     = (state_q == STREAM) & (cnt_q == '0);
  assign eop_c     = (state_q == STREAM) & (cnt_q == CNT_LAST);
  assign xfer      = valid_c & sink.sink_ready;
  assign eop_xfer  = xfer & eop_c;
  assign src_eop   = sink.source_valid & sink.source_eop;
  // After an EOP read the FIFO still holds data if another entry remains or one
  // is being written; then the next SOP follows without an ARM bubble.
  assign more_next = (fifo_level > LVL_ONE) | in_valid;

`ifdef FFT_SEQ_ERR_ABORT_EN
  logic abort, hold_q, hold_d;

  assign abort    = sink.source_valid & (sink.source_error != 2'b00);
  assign flush    = abort;
  assign start_ok = enable & !hold_q;

  // After an abort, a restart needs enable to be seen low first.
  always_comb begin
    hold_d = hold_q;
    if (!enable) hold_d = 1'b0;
    if (abort)   hold_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) hold_q <= 1'b0;
    else          hold_q <= hold_d;
  end
`else
  logic unused_source_error;

  assign unused_source_error = ^sink.source_error;
  assign flush    = 1'b0;
  assign start_ok = enable;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    inv_d    = inv_q;
    frames_d = frames_q;
    ovf_d    = ovf_q;
    outst_d  = outst_q;

    case (state_q)
      IDLE: if (start_ok) state_d = ARM;
      ARM: begin
        if (!fifo_empty) begin
          inv_d   = inverse_cfg;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (eop_c) begin
            cnt_d    = '0;
            frames_d = frames_q + 16'd1;
            if (enable && more_next) inv_d = inverse_cfg;
            else if (enable)         state_d = ARM;
            else                     state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_valid && fifo_full && !xfer && !flush) ovf_d = 1'b1;

    if (eop_xfer && !src_eop && outst_q != 4'd15)  outst_d = outst_q + 4'd1;
    else if (src_eop && !eop_xfer && outst_q != '0) outst_d = outst_q - 4'd1;

`ifdef FFT_SEQ_ERR_ABORT_EN
    if (abort) begin
      cnt_d   = '0;
      outst_d = '0;
      state_d = IDLE;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      inv_q    <= 1'b0;
      frames_q <= '0;
      ovf_q    <= 1'b0;
      outst_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      inv_q    <= inv_d;
      frames_q <= frames_d;
      ovf_q    <= ovf_d;
      outst_q  <= outst_d;
    end
  end

  assign sink.sink_valid = valid_c;
  assign sink.sink_sop   = sop_c;
  assign sink.sink_eop   = eop_c;
  assign sink.sink_real  = valid_c ? fifo_head : '0;
  assign sink.sink_imag  = '0;
  assign sink.sink_error = 2'b00;

  assign inverse     = inv_q;
  assign fft_pts     = fft_pts_f(NPTS);
  assign frames_sent = frames_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == STREAM) | (outst_q != '0);

endmodule

// File: tb/tb_fft_stream_sequencer.sv
// Scoreboard bench for fft_stream_sequencer (NPTS=16, FIFO_DEPTH=4); covers the
// abort path when FFT_SEQ_ERR_ABORT_EN is defined.
module tb_fft_stream_sequencer;
  localparam int unsigned DATA_W = 14;
  localparam int unsigned NPTS   = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              inverse_cfg = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              inverse;
  logic [10:0]       fft_pts;
  logic [15:0]       frames_sent;
  logic              overflow;
  logic              busy;

  fft_stream_sequencer_if #(.DATA_W(DATA_W)) sif ();

  fft_stream_sequencer #(
    .DATA_W     (DATA_W),
    .NPTS       (NPTS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .inverse_cfg (inverse_cfg),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .sink        (sif),
    .inverse     (inverse),
    .fft_pts     (fft_pts),
    .frames_sent (frames_sent),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [DATA_W-1:0] din = 14'h0100;
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       exp_beat = 0;
  logic [15:0]       exp_frames = '0;
  logic              exp_ovf = 1'b0;
  bit                mon_en = 1'b0;
  bit                hold_chk = 1'b0;
  logic [DATA_W-1:0] held_real;
  logic              held_sop, held_eop;
  int unsigned       mon_occ;
  logic              mon_xf;
  logic [DATA_W-1:0] mon_e;
  logic              mon_sop, mon_eop;

  // Scoreboard: predicted FIFO contents, beat position, frame count and overflow.
  always @(negedge clk) begin
    if (reset_n && mon_en) begin
      tests++;
      if (overflow !== exp_ovf) begin
        fails++;
        $display("FAIL overflow_flag: got %b required %b at %0t", overflow, exp_ovf, $time);
      end
      tests++;
      if (frames_sent !== exp_frames) begin
        fails++;
        $display("FAIL frames_sent: got %0d required %0d at %0t", frames_sent, exp_frames, $time);
      end
      if (hold_chk) begin
        tests++;
        if (sif.sink_valid !== 1'b1 || sif.sink_real !== held_real ||
            sif.sink_sop !== held_sop || sif.sink_eop !== held_eop) begin
          fails++;
          $display("FAIL stall_hold: got v=%b d=%h sop=%b eop=%b required v=1 d=%h sop=%b eop=%b",
                   sif.sink_valid, sif.sink_real, sif.sink_sop, sif.sink_eop,
                   held_real, held_sop, held_eop);
        end
      end
      mon_occ = exp_q.size();
      mon_xf  = sif.sink_valid & sif.sink_ready;
      if (mon_xf) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected: got d=%h required no beat at %0t", sif.sink_real, $time);
        end else begin
          mon_e   = exp_q.pop_front();
          mon_sop = (exp_beat == 0);
          mon_eop = (exp_beat == NPTS - 1);
          if (sif.sink_real !== mon_e || sif.sink_sop !== mon_sop || sif.sink_eop !== mon_eop) begin
            fails++;
            $display("FAIL beat_%0d: got d=%h sop=%b eop=%b required d=%h sop=%b eop=%b",
                     exp_beat, sif.sink_real, sif.sink_sop, sif.sink_eop, mon_e, mon_sop, mon_eop);
          end
          if (mon_eop) exp_frames = exp_frames + 16'd1;
          exp_beat = mon_eop ? 0 : exp_beat + 1;
        end
      end
      hold_chk  = sif.sink_valid & !sif.sink_ready;
      held_real = sif.sink_real;
      held_sop  = sif.sink_sop;
      held_eop  = sif.sink_eop;
      if (in_valid) begin
        if (mon_occ < DEPTH || mon_xf) exp_q.push_back(in_data);
        else exp_ovf = 1'b1;
      end
    end
  end

  task automatic sb_reset();
    exp_q.delete();
    exp_beat   = 0;
    exp_frames = '0;
    exp_ovf    = 1'b0;
    hold_chk   = 1'b0;
  endtask

  task automatic cycle(input logic iv);
    @(posedge clk);
    #1;
    in_valid = iv;
    if (iv) begin
      in_data = din;
      din     = din + DATA_W'(1);
    end
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset_n          = 1'b0;
    in_valid         = 1'b0;
    enable           = 1'b0;
    inverse_cfg      = 1'b0;
    sif.sink_ready   = 1'b0;
    sif.source_valid = 1'b0;
    sif.source_eop   = 1'b0;
    sif.source_error = 2'b00;
    sb_reset();
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_frames(input logic [15:0] target, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (exp_frames < target && n < budget) begin
      cycle(1'b1);
      n++;
    end
    tests++;
    if (exp_frames < target) begin
      fails++;
      $display("FAIL %s_timeout: got frames=%0d required %0d", name, exp_frames, target);
    end
  endtask

  task automatic run_beat(input logic [15:0] frames, input int unsigned beat,
                          input int unsigned budget, input string name);
    int unsigned n = 0;
    while (!(exp_frames == frames && exp_beat >= beat) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    tests++;
    if (!(exp_frames == frames && exp_beat >= beat)) begin
      fails++;
      $display("FAIL %s_timeout: got frame=%0d beat=%0d required frame=%0d beat=%0d",
               name, exp_frames, exp_beat, frames, beat);
    end
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (sif.sink_valid !== 1'b0 || sif.sink_sop !== 1'b0 || sif.sink_eop !== 1'b0 ||
        inverse !== 1'b0 || frames_sent !== 16'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got v=%b sop=%b eop=%b inv=%b fr=%0d ovf=%b busy=%b required all 0",
               sif.sink_valid, sif.sink_sop, sif.sink_eop, inverse, frames_sent, overflow, busy);
    end
    tests++;
    if (fft_pts !== 11'd16) begin
      fails++;
      $display("FAIL fft_pts: got %0d required 16", fft_pts);
    end
    tests++;
    if (sif.sink_imag !== '0 || sif.sink_error !== 2'b00) begin
      fails++;
      $display("FAIL sink_consts: got imag=%h err=%b required 0/00", sif.sink_imag, sif.sink_error);
    end
  endtask

  task automatic test_stream();
    apply_reset();
    enable         = 1'b1;
    sif.sink_ready = 1'b1;
    run_frames(16'd2, 60, "stream_f2");
    enable = 1'b0;
    run_frames(16'd3, 30, "stream_f3");
    repeat (3) cycle(1'b0);
    tests++;
    if (frames_sent !== 16'd3 || overflow !== 1'b0 || sif.sink_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL stream_end: got fr=%0d ovf=%b v=%b busy=%b required 3/0/0/1",
               frames_sent, overflow, sif.sink_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int unsigned n = 0;
    apply_reset();
    enable = 1'b1;
    while (exp_frames < 16'd1 && n < 200) begin
      cycle(n[0] == 1'b0);
      sif.sink_ready = n[0];
      n++;
    end
    tests++;
    if (exp_frames < 16'd1 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL backpressure: got frames=%0d ovf=%b required 1/0", exp_frames, overflow);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    enable         = 1'b1;
    sif.sink_ready = 1'b0;
    repeat (10) cycle(1'b1);
    cycle(1'b0);
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_set: got %b required 1", overflow);
    end
    sif.sink_ready = 1'b1;
    run_frames(16'd1, 60, "overflow_frame");
    cycle(1'b0);
    tests++;
    if (frames_sent !== 16'd1 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_after: got fr=%0d ovf=%b required 1/1", frames_sent, overflow);
    end
  endtask

  task automatic test_enable_drop();
    apply_reset();
    enable         = 1'b1;
    sif.sink_ready = 1'b1;
    run_beat(16'd0, 5, 30, "endrop_beat5");
    enable = 1'b0;
    run_frames(16'd1, 30, "endrop_eop");
    repeat (6) cycle(1'b0);
    tests++;
    if (sif.sink_valid !== 1'b0 || frames_sent !== 16'd1 || exp_beat != 0) begin
      fails++;
      $display("FAIL enable_drop: got v=%b fr=%0d beat=%0d required 0/1/0",
               sif.sink_valid, frames_sent, exp_beat);
    end
  endtask

  task automatic test_inverse_busy();
    apply_reset();
    inverse_cfg    = 1'b1;
    enable         = 1'b1;
    sif.sink_ready = 1'b1;
    run_beat(16'd0, 4, 30, "inv_f1");
    tests++;
    if (inverse !== 1'b1) begin
      fails++;
      $display("FAIL inverse_f1: got %b required 1", inverse);
    end
    inverse_cfg = 1'b0;
    run_beat(16'd0, 10, 20, "inv_mid");
    tests++;
    if (inverse !== 1'b1) begin
      fails++;
      $display("FAIL inverse_hold: got %b required 1", inverse);
    end
    run_beat(16'd1, 2, 30, "inv_f2");
    tests++;
    if (inverse !== 1'b0) begin
      fails++;
      $display("FAIL inverse_f2: got %b required 0", inverse);
    end
    enable = 1'b0;
    run_frames(16'd2, 30, "inv_end");
    repeat (3) cycle(1'b0);
    tests++;
    if (busy !== 1'b1 || sif.sink_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_two_out: got busy=%b v=%b required 1/0", busy, sif.sink_valid);
    end
    sif.source_valid = 1'b1;
    sif.source_eop   = 1'b1;
    cycle(1'b0);
    sif.source_valid = 1'b0;
    sif.source_eop   = 1'b0;
    cycle(1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_one_out: got %b required 1", busy);
    end
    sif.source_valid = 1'b1;
    sif.source_eop   = 1'b1;
    cycle(1'b0);
    sif.source_valid = 1'b0;
    sif.source_eop   = 1'b0;
    cycle(1'b0);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL busy_clear: got %b required 0", busy);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    inverse_cfg    = 1'b1;
    enable         = 1'b1;
    sif.sink_ready = 1'b1;
    run_beat(16'd1, 6, 50, "areset_mid");
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    tests++;
    if (sif.sink_valid !== 1'b0 || sif.sink_sop !== 1'b0 || sif.sink_eop !== 1'b0 ||
        sif.sink_real !== '0 || inverse !== 1'b0 || frames_sent !== 16'd0 ||
        overflow !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got v=%b sop=%b eop=%b d=%h inv=%b fr=%0d ovf=%b busy=%b required all 0",
               sif.sink_valid, sif.sink_sop, sif.sink_eop, sif.sink_real, inverse,
               frames_sent, overflow, busy);
    end
    in_valid = 1'b0;
    enable   = 1'b0;
    sb_reset();
    #10;
    reset_n = 1'b1;
  endtask

`ifdef FFT_SEQ_ERR_ABORT_EN
  task automatic test_error_abort();
    int unsigned n;
    bit seen_valid;
    apply_reset();
    enable         = 1'b1;
    sif.sink_ready = 1'b1;
    run_beat(16'd0, 4, 30, "abort_mid");
    mon_en   = 1'b0;
    hold_chk = 1'b0;
    sif.source_valid = 1'b1;
    sif.source_error = 2'b01;
    cycle(1'b1);
    sif.source_valid = 1'b0;
    sif.source_error = 2'b00;
    tests++;
    if (sif.sink_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_drop: got v=%b busy=%b required 0/0", sif.sink_valid, busy);
    end
    seen_valid = 1'b0;
    repeat (8) begin
      cycle(1'b1);
      if (sif.sink_valid !== 1'b0) seen_valid = 1'b1;
    end
    tests++;
    if (seen_valid) begin
      fails++;
      $display("FAIL abort_hold: got sink_valid=1 required 0 while enable held high");
    end
    enable = 1'b0;
    cycle(1'b1);
    enable = 1'b1;
    n = 0;
    while (sif.sink_valid !== 1'b1 && n < 10) begin
      cycle(1'b1);
      n++;
    end
    tests++;
    if (sif.sink_valid !== 1'b1) begin
      fails++;
      $display("FAIL abort_restart: got sink_valid=%b required 1 after enable toggle", sif.sink_valid);
    end
    cycle(1'b0);
  endtask
`endif

  initial begin
    sif.sink_ready   = 1'b0;
    sif.source_valid = 1'b0;
    sif.source_eop   = 1'b0;
    sif.source_error = 2'b00;
    test_reset();
    reset_n = 1'b1;
    test_stream();
    test_backpressure();
    test_overflow();
    test_enable_drop();
    test_inverse_busy();
    test_async_reset();
`ifdef FFT_SEQ_ERR_ABORT_EN
    test_error_abort();
`endif
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
